// File: rtl/board_score_keeper.sv
// Registered tic-tac-toe game state: X/O occupancy boards with validated one-hot
// cell writes, a move counter, and saturating two-digit BCD win counters per player.
module board_score_keeper (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [8:0] almacenar_x,
  input  logic [8:0] almacenar_o,
  input  logic       resetPosiciones,
  input  logic       resetScore,
  input  logic       inc_x_score,
  input  logic       inc_o_score,
  output logic [8:0] x,
  output logic [8:0] o,
  output logic [3:0] move_count,
  output logic       board_full,
  output logic [7:0] score_x,
  output logic [7:0] score_o,
  output logic       write_error
);

  localparam logic [3:0] MAX_MOVES = 4'd9;
  localparam logic [7:0] BCD_MAX   = 8'h99;

  // Command semantics: almacenar_x/almacenar_o carry no handshake. Every cycle a
  // nonzero vector is a write request that is consumed that cycle, accepted or not;
  // a rejected request produces exactly one write_error pulse the next cycle.

  logic [8:0] r_x;
  logic [8:0] r_o;
  logic [3:0] r_move_count;
  logic       r_board_full;
  logic       r_write_error;
  logic [7:0] r_score_x;
  logic [7:0] r_score_o;
  logic       r_prev_inc_x;
  logic       r_prev_inc_o;

  logic [8:0] w_occupied;
  logic [8:0] w_occupied_after_x;
  logic       w_x_req;
  logic       w_o_req;
  logic       w_x_onehot;
  logic       w_o_onehot;
  logic       w_x_accept;
  logic       w_o_accept;
  logic       w_x_reject;
  logic       w_o_reject;
  logic [3:0] w_moves_added;
  logic [3:0] w_move_sum;
  logic [3:0] w_move_next;
  logic       w_x_edge;
  logic       w_o_edge;

  function automatic logic f_is_onehot(input logic [8:0] v);
    f_is_onehot = (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

  function automatic logic [7:0] f_bcd_inc(input logic [7:0] s);
    logic [7:0] res;
    if (s == BCD_MAX)
      res = s;
    else if (s[3:0] == 4'd9)
      res = {s[7:4] + 4'd1, 4'd0};
    else
      res = {s[7:4], s[3:0] + 4'd1};
    f_bcd_inc = res;
  endfunction

  always_comb begin
    w_occupied = r_x | r_o;
    w_x_req    = (almacenar_x != 9'd0);
    w_o_req    = (almacenar_o != 9'd0);
    w_x_onehot = f_is_onehot(almacenar_x);
    w_o_onehot = f_is_onehot(almacenar_o);
    w_x_accept = w_x_onehot && ((almacenar_x & w_occupied) == 9'd0);
    // X is resolved first, so an O write to the cell X takes this cycle is refused.
    w_occupied_after_x = w_occupied | (w_x_accept ? almacenar_x : 9'd0);
    w_o_accept = w_o_onehot && ((almacenar_o & w_occupied_after_x) == 9'd0);
    w_x_reject = w_x_req && !w_x_accept;
    w_o_reject = w_o_req && !w_o_accept;
    w_moves_added = {3'd0, w_x_accept} + {3'd0, w_o_accept};
    w_move_sum    = r_move_count + w_moves_added;
    w_move_next   = (w_move_sum > MAX_MOVES) ? MAX_MOVES : w_move_sum;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_x           <= 9'd0;
      r_o           <= 9'd0;
      r_move_count  <= 4'd0;
      r_board_full  <= 1'b0;
      r_write_error <= 1'b0;
    end else if (resetPosiciones) begin
      r_x           <= 9'd0;
      r_o           <= 9'd0;
      r_move_count  <= 4'd0;
      r_board_full  <= 1'b0;
      r_write_error <= 1'b0;
    end else begin
      if (w_x_accept) r_x <= r_x | almacenar_x;
      if (w_o_accept) r_o <= r_o | almacenar_o;
      r_move_count  <= w_move_next;
      r_board_full  <= (w_move_next == MAX_MOVES);
      r_write_error <= w_x_reject || w_o_reject;
    end
  end

  always_comb begin
    w_x_edge = inc_x_score && !r_prev_inc_x;
    w_o_edge = inc_o_score && !r_prev_inc_o;
  end

  // Edge history tracks the inputs even while resetScore is held, so a held
  // inc_* is not counted again once the score clear is released.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_prev_inc_x <= 1'b0;
      r_prev_inc_o <= 1'b0;
      r_score_x    <= 8'd0;
      r_score_o    <= 8'd0;
    end else begin
      r_prev_inc_x <= inc_x_score;
      r_prev_inc_o <= inc_o_score;
      if (resetScore) begin
        r_score_x <= 8'd0;
        r_score_o <= 8'd0;
      end else begin
        if (w_x_edge) r_score_x <= f_bcd_inc(r_score_x);
        if (w_o_edge) r_score_o <= f_bcd_inc(r_score_o);
      end
    end
  end

  assign x           = r_x;
  assign o           = r_o;
  assign move_count  = r_move_count;
  assign board_full  = r_board_full;
  assign write_error = r_write_error;
  assign score_x     = r_score_x;
  assign score_o     = r_score_o;

endmodule

// File: doc/board_score_keeper.md
# board_score_keeper

Registered game-state store for the tic-tac-toe datapath, sitting at the receiving end of the game controller's store/score command outputs. It accepts one-hot cell-write commands for X and O, holds the two 9-bit occupancy boards that feed back into the controller, and keeps two-digit BCD win counters for each player. All outputs are registered and drive both the controller and the VGA/display logic.

## Interface
- No parameters.
- clk_100MHz  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears every register
- almacenar_x  in  9  X write command, one-hot cell index (bit i = cell i), 0 = no write
- almacenar_o  in  9  O write command, same encoding
- resetPosiciones  in  1  level; clears both boards and move count
- resetScore  in  1  level; clears both score counters
- inc_x_score  in  1  level, may be held many cycles; rising edge = one X win
- inc_o_score  in  1  level, may be held many cycles; rising edge = one O win
- x  out  9  X occupancy board
- o  out  9  O occupancy board
- move_count  out  4  accepted writes since last board clear, 0..9
- board_full  out  1  high when move_count == 9
- score_x  out  8  X wins, BCD {tens[7:4], units[3:0]}, 00..99
- score_o  out  8  O wins, BCD, same format
- write_error  out  1  one-cycle pulse on a rejected write

## Operation
- Reset value of every output and internal register: 0 (including edge-detect history).
- Board clear priority: reset > resetPosiciones > writes. During clear, writes ignored, write_error stays 0.
- Write acceptance (evaluated per cycle, independently for X then O):
  - vector must be exactly one-hot; zero vector = no-op, no error.
  - multi-hot vector -> entire vector ignored, write_error pulses.
  - target cell must be free (x[i]==0 and o[i]==0) -> else ignored, write_error pulses.
  - accepted write sets x[i] (or o[i]) and increments move_count.
- Simultaneous X and O writes in one cycle:
  - different free cells: both accepted, move_count += 2.
  - same free cell: X wins, O rejected, write_error pulses.
- move_count saturates at 9 (cannot exceed since only 9 cells exist; any write when full is an occupied-cell rejection).
- Score edge detection: registered prev_inc_x / prev_inc_o; increment when inc && !prev. prev updated every cycle, including during resetScore.
- BCD increment: units 9 -> 0 with tens+1; 99 saturates at 99 (no wrap).
- resetScore has priority over a coinciding rising edge: result 00, edge consumed.
- Simultaneous X and O rising edges: both counters increment.
- Board and score domains independent: resetPosiciones does not touch scores; resetScore does not touch boards.

## Timing
- Write accepted in cycle N -> x/o, move_count, board_full updated at edge ending N (visible cycle N+1).
- write_error asserted exactly one cycle (cycle N+1) per rejecting cycle; consecutive rejecting cycles give consecutive pulses.
- Score updated one cycle after the rising edge of inc_*; holding inc high for any number of cycles counts once.
- resetPosiciones/resetScore/reset take effect at the next edge; outputs 0 in the following cycle.
- Reset mid-game: all boards, counters, scores, edge history cleared in one cycle; an inc_* still high after reset releases counts as a new rising edge.
- No combinational input-to-output paths.

## Test plan
- Reset then almacenar_x=9'b000010000 for 1 cycle -> next cycle x=9'h010, o=0, move_count=1, write_error=0.
- With x[4]=1, almacenar_o=9'h010 -> o unchanged, move_count unchanged, write_error pulses 1 cycle; almacenar_x=9'h003 -> ignored, write_error pulses.
- Same cycle almacenar_x=9'h001, almacenar_o=9'h001 on empty board -> x=9'h001, o=0, move_count=1, write_error=1; fill all 9 cells alternately -> board_full=1, then resetPosiciones -> x=o=0, move_count=0, scores unchanged.
- Hold inc_x_score high 50 cycles -> score_x=8'h01; pulse 9 more times -> 8'h10; drive to 8'h99 then one more edge -> stays 8'h99.
- resetScore asserted same cycle as inc_o_score rising edge with score_o=8'h05 -> score_o=8'h00 next cycle; inc_o_score still high afterwards -> no increment until it falls and rises.
- Assert reset while inc_x_score held high and board partially filled -> all outputs 0 next cycle; after reset release score_x becomes 8'h01 one cycle later.
